tx_mac_seq_ctrl: RTL and testbench

Sequencer in front of the 64-lane MAC datapath. Accepts one instruction at a time, optionally loads a bias vector, and pairs IFM and WFM beats into a single registered issue stream toward the MAC. Tags the first beat of each accumulation group with bias-add, detects the end of the instruction, and reports the MAC main-state and NaN/Inf exception.

---
 rtl/tx_pkg.sv | 41 ++++
 rtl/tx_mac_issue_reg.sv | 59 +++++
 rtl/tx_mac_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tx_mac_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types for the TX MAC front-end: instruction/beat/bias port structs,
// MAC main-state encoding and the issue sequencer state enum.
package tx_pkg;

    localparam int TX_MAC_LANES     = 64;
    localparam int TX_MAC_DATA_W    = 16;
    localparam int TX_MAC_BIAS_W    = 32;
    localparam int TX_MAC_SEQ_CNT_W = 16;

    typedef enum logic [1:0] {S_IDLE, S_BIAS, S_RUN, S_FLUSH} tx_mac_seq_state;

    typedef enum logic {MAC_IDLE = 1'b0, MAC_RUN = 1'b1} mac_main_state;

    typedef struct packed {
        logic [3:0] datatypes;
        logic       bias_enable;
        logic       bias_mode;
    } tx_mac_instruction_port;

    typedef struct packed {
        logic [TX_MAC_LANES-1:0][TX_MAC_BIAS_W-1:0] bias;
    } tx_mac_bias_port;

    typedef struct packed {
        logic [TX_MAC_LANES-1:0][TX_MAC_DATA_W-1:0] data;
        logic [TX_MAC_LANES-1:0]                    data_element_valid;
        logic                                       inter_end;
        logic                                       accum_end;
    } tx_mac_ifm_port;

    typedef struct packed {
        logic [TX_MAC_LANES-1:0][TX_MAC_DATA_W-1:0] data;
        logic                                       is_last;
    } tx_mac_wfm_port;

    typedef struct packed {
        mac_main_state main_fsm;
        logic          is_nan_or_inf;
    } tx_mac_exception_port;

endpackage

// File: rtl/tx_mac_issue_reg.sv
// Single-stage valid/ready register holding one paired IFM/WFM beat and its
// bias-add tag; contents are frozen while the consumer stalls.
module tx_mac_issue_reg
    import tx_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  tx_mac_ifm_port in_ifm,
    input  tx_mac_wfm_port in_wfm,
    input  logic           in_bias_add,
    input  logic           out_ready,
    output logic           out_valid,
    output tx_mac_ifm_port out_ifm,
    output tx_mac_wfm_port out_wfm,
    output logic           out_bias_add
);

    logic           valid_q, valid_d;
    tx_mac_ifm_port ifm_q, ifm_d;
    tx_mac_wfm_port wfm_q, wfm_d;
    logic           bias_add_q, bias_add_d;

    // load wins over drain so an accept and a new fire in one cycle leave no bubble
    always_comb begin
        valid_d    = valid_q;
        ifm_d      = ifm_q;
        wfm_d      = wfm_q;
        bias_add_d = bias_add_q;
        if (load) begin
            valid_d    = 1'b1;
            ifm_d      = in_ifm;
            wfm_d      = in_wfm;
            bias_add_d = in_bias_add;
        end else if (out_ready) begin
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ifm_q      <= '0;
            wfm_q      <= '0;
            bias_add_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            ifm_q      <= ifm_d;
            wfm_q      <= wfm_d;
            bias_add_q <= bias_add_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_ifm      = ifm_q;
    assign out_wfm      = wfm_q;
    assign out_bias_add = bias_add_q;

endmodule

// File: rtl/tx_mac_seq_ctrl.sv
// Instruction sequencer ahead of the 64-lane MAC: bias load, IFM/WFM pairing,
// group tagging, end-of-instruction detection and exception reporting.
module tx_mac_seq_ctrl
    import tx_pkg::*;
#(
    parameter int CNT_W = TX_MAC_SEQ_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  tx_mac_instruction_port instr,
    input  logic                   bias_valid,
    output logic                   bias_ready,
    input  tx_mac_bias_port        bias,
    input  logic                   ifm_valid,
    output logic                   ifm_ready,
    input  tx_mac_ifm_port         ifm,
    input  logic                   wfm_valid,
    output logic                   wfm_ready,
    input  tx_mac_wfm_port         wfm,
    output logic                   mac_valid,
    input  logic                   mac_ready,
    output tx_mac_instruction_port mac_cfg,
    output tx_mac_ifm_port         mac_ifm,
    output tx_mac_wfm_port         mac_wfm,
    output tx_mac_bias_port        mac_bias,
    output logic                   mac_bias_add,
    input  logic                   mac_nan_inf,
    output tx_mac_exception_port   exc,
    output logic                   seq_err,
    output logic                   done,
    output logic [CNT_W-1:0]       beat_cnt,
    output logic [CNT_W-1:0]       group_cnt
);

    tx_mac_seq_state        state_q, state_d;
    tx_mac_instruction_port cfg_q, cfg_d;
    tx_mac_bias_port        bias_q, bias_d;
    logic                   group_open_q, group_open_d;
    logic                   nan_q, nan_d;
    logic                   seq_err_q, seq_err_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]       group_cnt_q, group_cnt_d;

    logic fire;
    logic issue_valid;

    assign fire        = (state_q == S_RUN) & ifm_valid & wfm_valid & (~issue_valid | mac_ready);
    assign ifm_ready   = fire;
    assign wfm_ready   = fire;
    assign instr_ready = (state_q == S_IDLE);
    // A stalled beat must keep seeing the bias it was issued with
    assign bias_ready  = (state_q == S_BIAS) & (~issue_valid | mac_ready);

    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        bias_d       = bias_q;
        group_open_d = group_open_q;
        nan_d        = nan_q;
        seq_err_d    = seq_err_q;
        done_d       = 1'b0;
        beat_cnt_d   = beat_cnt_q;
        group_cnt_d  = group_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    cfg_d        = instr;
                    beat_cnt_d   = '0;
                    group_cnt_d  = '0;
                    nan_d        = 1'b0;
                    seq_err_d    = 1'b0;
                    group_open_d = 1'b1;
                    state_d      = instr.bias_enable ? S_BIAS : S_RUN;
                end
            end
            S_BIAS: begin
                if (bias_valid && bias_ready) begin
                    bias_d  = bias;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (fire) begin
                    group_open_d = ifm.accum_end;
                    if (beat_cnt_q != '1)
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    if (ifm.accum_end && group_cnt_q != '1)
                        group_cnt_d = group_cnt_q + 1'b1;
                    if (wfm.is_last) begin
                        state_d = S_FLUSH;
                        if (!ifm.accum_end)
                            seq_err_d = 1'b1;
                    end else if (ifm.accum_end && cfg_q.bias_enable && cfg_q.bias_mode) begin
                        state_d = S_BIAS;
                    end
                end
            end
            S_FLUSH: begin
                if (!issue_valid || mac_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && mac_nan_inf)
            nan_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cfg_q        <= '0;
            bias_q       <= '0;
            group_open_q <= 1'b0;
            nan_q        <= 1'b0;
            seq_err_q    <= 1'b0;
            done_q       <= 1'b0;
            beat_cnt_q   <= '0;
            group_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            bias_q       <= bias_d;
            group_open_q <= group_open_d;
            nan_q        <= nan_d;
            seq_err_q    <= seq_err_d;
            done_q       <= done_d;
            beat_cnt_q   <= beat_cnt_d;
            group_cnt_q  <= group_cnt_d;
        end
    end

    tx_mac_issue_reg u_issue (
        .clk          (clk),
        .rst          (rst),
        .load         (fire),
        .in_ifm       (ifm),
        .in_wfm       (wfm),
        .in_bias_add  (cfg_q.bias_enable & group_open_q),
        .out_ready    (mac_ready),
        .out_valid    (issue_valid),
        .out_ifm      (mac_ifm),
        .out_wfm      (mac_wfm),
        .out_bias_add (mac_bias_add)
    );

    assign mac_valid         = issue_valid;
    assign mac_cfg           = cfg_q;
    assign mac_bias          = bias_q;
    assign exc.main_fsm      = (state_q == S_IDLE) ? MAC_IDLE : MAC_RUN;
    assign exc.is_nan_or_inf = nan_q;
    assign seq_err           = seq_err_q;
    assign done              = done_q;
    assign beat_cnt          = beat_cnt_q;
    assign group_cnt         = group_cnt_q;

endmodule

// File: tb/tb_tx_mac_seq_ctrl.sv
// Directed bench for tx_mac_seq_ctrl; counters are narrowed so saturation is
// reachable in a few beats.
module tb_tx_mac_seq_ctrl;
    import tx_pkg::*;

    localparam int TB_CNT_W = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   instr_valid, instr_ready;
    tx_mac_instruction_port instr;
    logic                   bias_valid, bias_ready;
    tx_mac_bias_port        bias;
    logic                   ifm_valid, ifm_ready;
    tx_mac_ifm_port         ifm;
    logic                   wfm_valid, wfm_ready;
    tx_mac_wfm_port         wfm;
    logic                   mac_valid, mac_ready;
    tx_mac_instruction_port mac_cfg;
    tx_mac_ifm_port         mac_ifm;
    tx_mac_wfm_port         mac_wfm;
    tx_mac_bias_port        mac_bias;
    logic                   mac_bias_add;
    logic                   mac_nan_inf;
    tx_mac_exception_port   exc;
    logic                   seq_err, done;
    logic [TB_CNT_W-1:0]    beat_cnt, group_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tx_mac_seq_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .bias_valid(bias_valid), .bias_ready(bias_ready), .bias(bias),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm(ifm),
        .wfm_valid(wfm_valid), .wfm_ready(wfm_ready), .wfm(wfm),
        .mac_valid(mac_valid), .mac_ready(mac_ready),
        .mac_cfg(mac_cfg), .mac_ifm(mac_ifm), .mac_wfm(mac_wfm), .mac_bias(mac_bias),
        .mac_bias_add(mac_bias_add), .mac_nan_inf(mac_nan_inf),
        .exc(exc), .seq_err(seq_err), .done(done),
        .beat_cnt(beat_cnt), .group_cnt(group_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic tx_mac_ifm_port mk_ifm(input logic [7:0] tag, input logic ae, input logic ev);
        tx_mac_ifm_port f;
        f = '0;
        f.data[0] = {8'h00, tag};
        f.data[TX_MAC_LANES-1] = {tag, 8'h00};
        f.data_element_valid = ev ? '1 : '0;
        f.inter_end = tag[0];
        f.accum_end = ae;
        return f;
    endfunction

    function automatic tx_mac_wfm_port mk_wfm(input logic [7:0] tag, input logic last);
        tx_mac_wfm_port f;
        f = '0;
        f.data[0] = {8'h01, tag};
        f.is_last = last;
        return f;
    endfunction

    task automatic do_instr(input logic [3:0] dt, input logic be, input logic bm);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instr.datatypes = dt;
        instr.bias_enable = be;
        instr.bias_mode = bm;
        #1;
        while (!instr_ready && n < 20) begin tick(); n++; end
        check("instr_hs_bound", 32'(n < 20), 1);
        tick();
        instr_valid = 1'b0;
        check("mac_cfg", 32'(mac_cfg), {26'd0, dt, be, bm});
    endtask

    task automatic do_bias(input logic [31:0] tag);
        int n;
        n = 0;
        bias_valid = 1'b1;
        bias = '0;
        bias.bias[0] = tag;
        #1;
        while (!bias_ready && n < 20) begin tick(); n++; end
        check("bias_hs_bound", 32'(n < 20), 1);
        tick();
        bias_valid = 1'b0;
        check("mac_bias_lane0", mac_bias.bias[0], tag);
    endtask

    // One paired beat; assumes the previous beat drains (mac_ready=1) or the register is empty
    task automatic do_beat(input logic [7:0] tag, input logic ae, input logic last,
                           input logic exp_badd, input logic ev);
        int n;
        n = 0;
        ifm_valid = 1'b1;
        wfm_valid = 1'b1;
        ifm = mk_ifm(tag, ae, ev);
        wfm = mk_wfm(tag, last);
        #1;
        while (!ifm_ready && n < 20) begin tick(); n++; end
        check("beat_fire_bound", 32'(n < 20), 1);
        check("beat_rdy_pair", 32'(wfm_ready), 32'(ifm_ready));
        tick();
        ifm_valid = 1'b0;
        wfm_valid = 1'b0;
        check("beat_mac_valid", 32'(mac_valid), 1);
        check("beat_ifm", {15'd0, mac_ifm.inter_end, mac_ifm.data[0]}, {15'd0, tag[0], 8'h00, tag});
        check("beat_ifm_ev", 32'(mac_ifm.data_element_valid[5]), 32'(ev));
        check("beat_wfm", 32'(mac_wfm.data[0]), {16'd0, 8'h01, tag});
        check("beat_bias_add", 32'(mac_bias_add), 32'(exp_badd));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        ifm_valid = 1'b0;
        wfm_valid = 1'b0;
        while (!done && n < 20) begin tick(); n++; end
        check(tag, 32'(done), 1);
        tick();
    endtask

    initial begin
        int ii, rx;
        logic stalled, fired;
        logic [15:0] held;

        rst = 1'b1;
        instr_valid = 1'b0; instr = '0;
        bias_valid = 1'b0;  bias = '0;
        ifm_valid = 1'b0;   ifm = '0;
        wfm_valid = 1'b0;   wfm = '0;
        mac_ready = 1'b1;   mac_nan_inf = 1'b0;
        tick(); tick();

        // reset state
        check("rst_instr_ready", 32'(instr_ready), 1);
        check("rst_bias_ready", 32'(bias_ready), 0);
        check("rst_ifm_ready", 32'(ifm_ready), 0);
        check("rst_mac_valid", 32'(mac_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_exc", 32'(exc), 0);
        check("rst_cnts", {beat_cnt, group_cnt}, 0);
        check("rst_cfg", 32'(mac_cfg), 0);
        rst = 1'b0;
        tick();

        // no bias, single group of 4
        do_instr(4'h1, 1'b0, 1'b0);
        do_beat(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        do_beat(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        do_beat(8'h13, 1'b0, 1'b0, 1'b0, 1'b1);
        do_beat(8'h14, 1'b1, 1'b1, 1'b0, 1'b1);
        check("s1_beat_cnt", 32'(beat_cnt), 4);
        check("s1_group_cnt", 32'(group_cnt), 1);
        check("s1_no_done_yet", 32'(done), 0);
        check("s1_instr_blocked", 32'(instr_ready), 0);
        tick();
        check("s1_done", 32'(done), 1);
        check("s1_instr_ready_with_done", 32'(instr_ready), 1);
        check("s1_mac_idle", 32'(mac_valid), 0);
        check("s1_exc_idle", 32'(exc), 0);
        tick();
        check("s1_done_pulse", 32'(done), 0);

        // bias reused across groups of 3+2
        do_instr(4'h2, 1'b1, 1'b0);
        check("s2_in_bias", 32'(bias_ready), 1);
        do_bias(32'hB1B1_0001);
        do_beat(8'h21, 1'b0, 1'b0, 1'b1, 1'b1);
        do_beat(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        do_beat(8'h23, 1'b1, 1'b0, 1'b0, 1'b1);
        check("s2_no_reload", 32'(bias_ready), 0);
        do_beat(8'h24, 1'b0, 1'b0, 1'b1, 1'b1);
        do_beat(8'h25, 1'b1, 1'b1, 1'b0, 1'b1);
        check("s2_group_cnt", 32'(group_cnt), 2);
        check("s2_bias_kept", mac_bias.bias[0], 32'hB1B1_0001);
        wait_done("s2_done");

        // bias reload per group
        do_instr(4'h3, 1'b1, 1'b1);
        do_bias(32'hC1C1_0001);
        do_beat(8'h31, 1'b0, 1'b0, 1'b1, 1'b1);
        do_beat(8'h32, 1'b1, 1'b0, 1'b0, 1'b1);
        ifm_valid = 1'b1; wfm_valid = 1'b1;
        ifm = mk_ifm(8'h33, 1'b0, 1'b1); wfm = mk_wfm(8'h33, 1'b0);
        #1;
        check("s3_no_fire_in_bias", 32'(ifm_ready), 0);
        check("s3_bias_ready", 32'(bias_ready), 1);
        do_bias(32'hC2C2_0002);
        check("s3_drained", 32'(mac_valid), 0);
        check("s3_beat_cnt", 32'(beat_cnt), 2);
        do_beat(8'h33, 1'b0, 1'b0, 1'b1, 1'b1);
        do_beat(8'h34, 1'b1, 1'b1, 1'b0, 1'b1);
        check("s3_bias_beat4", mac_bias.bias[0], 32'hC2C2_0002);
        check("s3_group_cnt", 32'(group_cnt), 2);
        wait_done("s3_done");

        // backpressure with skewed IFM/WFM
        do_instr(4'h4, 1'b0, 1'b0);
        ii = 0; rx = 0;
        for (int c = 0; c < 60 && rx < 4; c++) begin
            ifm_valid = (ii < 4);
            wfm_valid = (c >= 2) && (ii < 4);
            ifm = mk_ifm(8'(8'h40 + ii + 1), ii == 3, 1'b1);
            wfm = mk_wfm(8'(8'h40 + ii + 1), ii == 3);
            mac_ready = c[0];
            #1;
            check("s4_rdy_pair", 32'(wfm_ready), 32'(ifm_ready));
            stalled = mac_valid && !mac_ready;
            held = mac_ifm.data[0];
            if (mac_valid && mac_ready) begin
                rx++;
                check("s4_order_ifm", 32'(mac_ifm.data[0]), 32'(8'h40 + rx));
                check("s4_order_wfm", 32'(mac_wfm.data[0]), 32'(16'h0140 + rx));
            end
            fired = ifm_ready;
            tick();
            if (stalled)
                check("s4_hold", {15'd0, mac_valid, mac_ifm.data[0]}, {15'd0, 1'b1, held});
            if (fired) ii++;
        end
        ifm_valid = 1'b0; wfm_valid = 1'b0; mac_ready = 1'b1;
        check("s4_all_received", 32'(rx), 4);
        check("s4_done", 32'(done), 1);
        check("s4_beat_cnt", 32'(beat_cnt), 4);
        tick();

        // counter saturation with all-zero element-valid beats
        do_instr(4'h5, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            do_beat(8'(8'h50 + k), 1'b1, k == 9, 1'b0, 1'b0);
            check("s5_beat_sat", 32'(beat_cnt), (k > 7) ? 7 : k);
        end
        check("s5_group_sat", 32'(group_cnt), 7);
        wait_done("s5_done");

        // sequence error and sticky NaN/Inf
        do_instr(4'h6, 1'b0, 1'b0);
        do_beat(8'h61, 1'b0, 1'b0, 1'b0, 1'b1);
        mac_nan_inf = 1'b1;
        tick();
        mac_nan_inf = 1'b0;
        check("s6_nan_set", 32'(exc), 32'b11);
        tick();
        check("s6_nan_sticky", 32'(exc), 32'b11);
        check("s6_no_err_yet", 32'(seq_err), 0);
        do_beat(8'h62, 1'b0, 1'b1, 1'b0, 1'b1);
        check("s6_seq_err", 32'(seq_err), 1);
        wait_done("s6_done");
        check("s6_exc_idle_sticky", 32'(exc), 32'b01);
        check("s6_seq_err_held", 32'(seq_err), 1);
        mac_nan_inf = 1'b1;
        tick();
        mac_nan_inf = 1'b0;
        check("s6_nan_idle_hold", 32'(exc), 32'b01);
        do_instr(4'h7, 1'b0, 1'b0);
        check("s6_exc_cleared", 32'(exc), 32'b10);
        check("s6_err_cleared", 32'(seq_err), 0);
        check("s6_cnt_cleared", {beat_cnt, group_cnt}, 0);

        // reset with a stalled beat in flight
        mac_ready = 1'b0;
        do_beat(8'h71, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("s7_stalled", {15'd0, mac_valid, mac_ifm.data[0]}, {15'd0, 1'b1, 16'h0071});
        rst = 1'b1;
        tick();
        check("s7_mac_valid", 32'(mac_valid), 0);
        check("s7_done", 32'(done), 0);
        check("s7_instr_ready", 32'(instr_ready), 1);
        check("s7_cnt", {beat_cnt, group_cnt}, 0);
        check("s7_cfg", 32'(mac_cfg), 0);
        check("s7_exc", 32'(exc), 0);
        check("s7_ifm", 32'(mac_ifm.data[0]), 0);
        rst = 1'b0;
        mac_ready = 1'b1;
        tick();
        check("s7_no_done_after", 32'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
